// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with prescaler and double-buffered duty registers.
// Byte-wide register write port; all outputs registered.
module pwm_multi_channel #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  localparam int NB  = NUM_CH / 8;
  localparam int MAX = (1 << CNT_W) - 1;

  localparam logic [ADDR_W-1:0] A_DIV = ADDR_W'(2 * NB + NUM_CH);
  localparam logic [CNT_W-1:0]  C_END = CNT_W'(MAX - 1);

  logic [NUM_CH-1:0] en_out;
  logic [NUM_CH-1:0] en_pwm;
  logic [NUM_CH-1:0] out_nxt;
  logic [7:0]        div;
  logic [7:0]        pre_cnt;
  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic              wrap;
  logic              div_we;

  assign tick   = (pre_cnt == div);
  assign wrap   = tick && (cnt == C_END);
  assign div_we = wr_en && (wr_addr == A_DIV);

  always_ff @(posedge clk) begin
    if (rst) begin
      en_out <= '0;
      en_pwm <= '0;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (wr_en && wr_addr == ADDR_W'(k))
          en_out[8*k +: 8] <= wr_data;
        if (wr_en && wr_addr == ADDR_W'(NB + k))
          en_pwm[8*k +: 8] <= wr_data;
      end
    end
  end

  // A div write restarts the prescale phase so the new rate is clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      pre_cnt <= '0;
    end else begin
      if (div_we)
        div <= wr_data;
      if (div_we || tick)
        pre_cnt <= '0;
      else
        pre_cnt <= pre_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (tick)
        cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] shd;
    logic [CNT_W-1:0] act;
    logic             dw;

    assign dw = wr_en && (wr_addr == ADDR_W'(2 * NB + i));

    // Forward a same-cycle write so it is not lost at the wrap.
    always_ff @(posedge clk) begin
      if (rst) begin
        shd <= '0;
        act <= '0;
      end else begin
        if (dw)
          shd <= wr_data[CNT_W-1:0];
        if (wrap)
          act <= dw ? wr_data[CNT_W-1:0] : shd;
      end
    end

    assign out_nxt[i] = en_out[i] & (~en_pwm[i] | (cnt < act));
  end

  always_ff @(posedge clk) begin
    if (rst)
      out <= '0;
    else
      out <= out_nxt;
  end

endmodule
